// File: rtl/etapa_if.sv
// etapa_if: instruction-fetch stage with one-entry skid buffer and branch redirect.
// Optional HALT-opcode fetch stop is compiled in when IF_HALT_EN is defined.
module etapa_if #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [13:0]     imem_data,
    output logic [13:0]     instruccion,
    output logic [PC_W-1:0] pc_out,
    output logic            valid_out,
    output logic            halted
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] req_pc;
    logic            rsp_pend;
    logic            skid_v;
    logic [13:0]     skid_ins;
    logic [PC_W-1:0] skid_pc;
    logic            stop;
    logic            rsp_ok;

`ifdef IF_HALT_EN
    logic halt_q;
    logic halt_set;

    assign stop     = halt_q;
    assign halted   = halt_q;
    // rsp_ok always lands the word in the output or skid slot
    assign halt_set = rsp_ok & (imem_data[13:10] == 4'b1111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else if (halt_set) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign stop   = 1'b0;
    assign halted = 1'b0;
`endif

    assign imem_rd   = rst_n & ~branch_taken & ~stall & ~stop;
    assign imem_addr = pc;
    assign rsp_ok    = rsp_pend & ~branch_taken & ~stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_W'(RESET_PC);
            req_pc      <= '0;
            rsp_pend    <= 1'b0;
            skid_v      <= 1'b0;
            skid_ins    <= '0;
            skid_pc     <= '0;
            instruccion <= '0;
            pc_out      <= '0;
            valid_out   <= 1'b0;
        end else begin
            rsp_pend <= imem_rd;
            if (imem_rd) begin
                req_pc <= pc;
                pc     <= pc + PC_W'(1);
            end

            if (branch_taken) begin
                pc          <= branch_target;
                valid_out   <= 1'b0;
                instruccion <= '0;
                skid_v      <= 1'b0;
            end else if (!stall) begin
                if (skid_v) begin
                    instruccion <= skid_ins;
                    pc_out      <= skid_pc;
                    valid_out   <= 1'b1;
                    skid_v      <= 1'b0;
                end else if (rsp_ok) begin
                    instruccion <= imem_data;
                    pc_out      <= req_pc;
                    valid_out   <= 1'b1;
                end else begin
                    valid_out   <= 1'b0;
                    instruccion <= '0;
                end
            end else if (rsp_ok) begin
                // Under stall a bubble is replaced; a valid word is held and the response parks in skid
                if (!valid_out) begin
                    instruccion <= imem_data;
                    pc_out      <= req_pc;
                    valid_out   <= 1'b1;
                end else begin
                    skid_ins <= imem_data;
                    skid_pc  <= req_pc;
                    skid_v   <= 1'b1;
                end
            end
        end
    end

endmodule
